// File: rtl/flit_tx_credit_if.sv
// Ingress flit handshake, egress flit bus, credit-return channel and status of the ejection-link transmitter.
// The master modport drives the ingress side; the slave modport is the transmitter.
interface flit_tx_credit_if;
  logic [71:0] i_flit;
  logic        i_flit_valid;
  logic        o_flit_ready;
  logic [72:0] o_flit;
  logic [2:0]  i_credit;
  logic        i_credit_valid;
  logic [3:0]  o_credit_count;
  logic [4:0]  o_fifo_count;
  logic        o_err_framing;
  logic        o_err_credit_ovf;

  modport master (
    output i_flit, i_flit_valid, i_credit, i_credit_valid,
    input  o_flit_ready, o_flit, o_credit_count, o_fifo_count,
           o_err_framing, o_err_credit_ovf
  );

  modport slave (
    input  i_flit, i_flit_valid, i_credit, i_credit_valid,
    output o_flit_ready, o_flit, o_credit_count, o_fifo_count,
           o_err_framing, o_err_credit_ovf
  );
endinterface

// File: rtl/flit_tx_credit.sv
// Credit-gated flit transmitter: framing-checked ingress into a small FIFO, one-cycle registered egress.
// Ready comes from registered occupancy only; sends stall whenever the downstream credit count is zero.
module flit_tx_credit #(
  parameter int FIFO_DEPTH  = 4,
  parameter int CREDIT_INIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  flit_tx_credit_if.slave  bus
);
  localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);
  localparam logic [4:0] CINIT_C = 5'(CREDIT_INIT);

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  typedef enum logic {ST_IDLE, ST_PKT} state_t;

  logic [71:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [4:0]    r_fifo_cnt;
  logic [3:0]    r_credit;
  logic          r_out_vld;
  logic [71:0]   r_out_dat;
  logic          r_err_framing;
  logic          r_err_ovf;
  state_t        r_state;

  logic          w_ready;
  logic          w_accept;
  logic [1:0]    w_type;
  logic          w_legal;
  logic          w_push;
  logic          w_send;
  logic [4:0]    w_credit_ret;
  logic [4:0]    w_credit_sum;
  logic          w_ovf;

  assign w_ready  = (r_fifo_cnt != DEPTH_C);
  assign w_accept = bus.i_flit_valid & w_ready;
  assign w_type   = bus.i_flit[71:70];

  always_comb begin
    w_legal = 1'b0;
    case (r_state)
      ST_IDLE: w_legal = (w_type == T_HEAD) || (w_type == T_HT);
      ST_PKT:  w_legal = (w_type == T_BODY) || (w_type == T_TAIL);
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal flits still complete the handshake; they just never reach the FIFO.
  assign w_push = w_accept & w_legal;
  assign w_send = (r_fifo_cnt != 5'd0) && (r_credit != 4'd0);

  assign w_credit_ret = bus.i_credit_valid ? {2'b00, bus.i_credit} : 5'd0;
  assign w_credit_sum = {1'b0, r_credit} - 5'(w_send) + w_credit_ret;
  assign w_ovf        = (w_credit_sum > CINIT_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_err_framing <= 1'b0;
    end else if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (w_type == T_HEAD)
            r_state <= ST_PKT;
          else if (!w_legal)
            r_err_framing <= 1'b1;
        end
        ST_PKT: begin
          if (w_type == T_TAIL)
            r_state <= ST_IDLE;
          else if (!w_legal)
            r_err_framing <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= bus.i_flit;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= 5'd0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_send)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_send})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 5'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 5'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
    end else begin
      r_out_vld <= w_send;
      if (w_send)
        r_out_dat <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit  <= CINIT_C[3:0];
      r_err_ovf <= 1'b0;
    end else begin
      r_credit <= w_ovf ? CINIT_C[3:0] : w_credit_sum[3:0];
      if (w_ovf)
        r_err_ovf <= 1'b1;
    end
  end

  assign bus.o_flit_ready     = w_ready;
  assign bus.o_flit           = {r_out_vld, r_out_dat};
  assign bus.o_credit_count   = r_credit;
  assign bus.o_fifo_count     = r_fifo_cnt;
  assign bus.o_err_framing    = r_err_framing;
  assign bus.o_err_credit_ovf = r_err_ovf;
endmodule

// File: doc/flit_tx_credit.md
# flit_tx_credit

Credit-based flit transmitter for the network-to-node ejection link. It buffers flits arriving from the router's local output port and drives them onto the 73-bit flit bus consumed by a node's router interface. It sends only while downstream credits remain, and replenishes credits from the node's credit-return channel (3-bit credit, credit-valid). It also checks head/body/tail framing on the ingress side and drops malformed flits.

## Interface
- FIFO_DEPTH, 4: local flit buffer entries, power of two, 2..16.
- CREDIT_INIT, 4: downstream receive-buffer slots and credit counter reset value, 1..15.
- clk  input  1: single clock, all state on rising edge.
- rst_n  input  1: reset, asynchronous and active-low.
- i_flit  input  72: ingress flit. [71:70] type (01 head, 00 body, 10 tail, 11 head-tail), [69:65] destination node, [64] reserved, [63:0] data.
- i_flit_valid  input  1: ingress flit present.
- o_flit_ready  output  1: ingress accept; a transfer occurs when valid and ready are both high at an edge.
- o_flit  output  73: egress flit. [72] valid, [71:0] = accepted i_flit, unmodified.
- i_credit  input  3: number of slots returned, 0..7.
- i_credit_valid  input  1: i_credit is meaningful this cycle.
- o_credit_count  output  4: current credits.
- o_fifo_count  output  5: FIFO occupancy.
- o_err_framing  output  1: sticky; a flit was dropped for a framing violation.
- o_err_credit_ovf  output  1: sticky; the credit return exceeded CREDIT_INIT.

## Operation
- Reset values: o_flit = 0 (valid low), o_flit_ready = 1, o_credit_count = CREDIT_INIT, o_fifo_count = 0, both error flags 0, framing FSM = IDLE.
- o_flit_ready = (o_fifo_count != FIFO_DEPTH). It is driven from registered occupancy only. A pop in the same cycle does not raise ready when the FIFO is full.
- Ingress framing FSM, advanced on each accepted flit:
  - IDLE: head goes to PKT and is enqueued. Head-tail stays in IDLE and is enqueued. Body or tail is dropped, sets o_err_framing, and stays in IDLE.
  - PKT: body stays in PKT and is enqueued. Tail goes to IDLE and is enqueued. Head or head-tail is dropped, sets o_err_framing, and stays in PKT.
  - A dropped flit completes the handshake but does not occupy the FIFO.
- Send condition, evaluated each cycle: FIFO non-empty and o_credit_count > 0.
  - When true, the head FIFO entry is popped and registered onto o_flit with [72] = 1 for exactly one cycle.
  - Otherwise o_flit[72] = 0 and o_flit[71:0] holds its last value.
- Credit update per edge: next = count − send + (i_credit_valid ? i_credit : 0).
  - If next > CREDIT_INIT, the count saturates at CREDIT_INIT and o_err_credit_ovf is set.
  - i_credit_valid with i_credit = 0 is a no-op.
  - A send and a credit return in the same cycle net out as above.
- FIFO push and pop in the same cycle: occupancy is unchanged, and order is strict FIFO. Pointers wrap modulo FIFO_DEPTH.
- Sticky error flags clear only on reset.
- Reset asserted mid-operation: buffered flits are discarded, credits reload to CREDIT_INIT, and o_flit valid drops immediately (asynchronous reset).

## Timing
- Latency, with an empty FIFO and credits > 0: a flit accepted at edge E is output at edge E+1, so o_flit[72] is high from E+1 to E+2.
- Throughput is one flit per cycle while credits and data are available.
- A credit returned at edge E can enable a send at edge E+1 at the earliest.
- With credit count 0 and a FIFO push, o_flit stays invalid until the cycle after the first credit return.
- o_credit_count and o_fifo_count are registered and update at the same edge as the event that changes them.

## Test plan
- Reset, then one head-tail flit with data 0x40200000, destination 5 → o_flit = {1, flit} one cycle after acceptance; o_credit_count 4→3.
- Reset, then a head/body/body/tail packet sent back-to-back with no credit return → 4 consecutive valid output cycles, credit reaches 0. A fifth head flit is held in the FIFO (o_fifo_count = 1). Credit return i_credit = 2 → the head is sent the next cycle and credit ends at 1.
- Credits 0 and 5 flits offered → 4 accepted, o_flit_ready low on the 5th, o_fifo_count = 4. Return 4 credits → 4 sends in order; ready rises after the first pop.
- Body flit in IDLE, then head-tail inside PKT → both dropped, o_err_framing = 1, FIFO unchanged, FSM state unchanged.
- At count 3, a send plus i_credit = 2 in the same cycle → count 4. Next cycle i_credit = 3 with no send → count saturates at 4 and o_err_credit_ovf = 1.
- Assert rst_n low with 3 flits buffered and credit 1 → outputs return to reset values within the reset cycle. After release, the first new flit is sent with credit 4→3.
